// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and constants for the LEGv8 instruction fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {RUN, HALT, FAULT} fetch_state_t;
    localparam logic [31:0] HALT_WORD = 32'hb400001f;
    localparam int unsigned PC_STEP = 4;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem port, branch redirect and decode handshake of the fetch stage.
interface fetch_stage_if #(parameter int N = 64, parameter int AW = 6);
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_q;
    logic br_taken;
    logic [N-1:0] br_target;
    logic instr_valid;
    logic instr_ready;
    logic [31:0] instr;
    logic [N-1:0] instr_pc;
    logic halt;
    logic fault;
    modport master (
        output imem_addr, instr_valid, instr, instr_pc, halt, fault,
        input imem_q, br_taken, br_target, instr_ready
    );
    modport slave (
        input imem_addr, instr_valid, instr, instr_pc, halt, fault,
        output imem_q, br_taken, br_target, instr_ready
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with load enable, choosing between sequential step and redirect.
module fetch_pc_reg
    import fetch_pkg::*;
#(parameter int N = 64) (
    input logic clk,
    input logic reset,
    input logic en,
    input logic redirect,
    input logic [N-1:0] target,
    output logic [N-1:0] pc
);
    logic [N-1:0] pc_next;
    always_comb pc_next = redirect ? target : pc + N'(PC_STEP);
    always_ff @(posedge clk or posedge reset)
        if (reset) pc <= '0;
        else if (en) pc <= pc_next;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, reads imem and presents {instr, instr_pc} to decode over valid/ready.
// Define FETCH_HALT_DETECT_EN to freeze the stage after the halt word is loaded.
module fetch_stage
    import fetch_pkg::*;
#(parameter int N = 64, parameter int AW = 6) (
    input logic clk,
    input logic reset,
    fetch_stage_if.master bus
);
    fetch_state_t state, state_next;
    logic [N-1:0] pc;
    logic [N-1:0] instr_pc;
    logic [31:0] instr;
    logic valid, run, redirect, misaligned, load, halt_hit;
    always_comb begin
        run = state == RUN;
        redirect = run && bus.br_taken;
        misaligned = redirect && bus.br_target[1:0] != 2'b00;
        load = run && !bus.br_taken && (!valid || bus.instr_ready);
    end
`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit = load && bus.imem_q == HALT_WORD;
    assign bus.halt = state == HALT;
`else
    assign halt_hit = 1'b0;
    assign bus.halt = 1'b0;
`endif
    // A misaligned target leaves the PC where it was
    fetch_pc_reg #(.N(N)) u_pc (
        .clk,
        .reset,
        .en(load || (redirect && !misaligned)),
        .redirect,
        .target(bus.br_target),
        .pc
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= RUN;
        else state <= state_next;
    always_comb state_next = misaligned ? FAULT : halt_hit ? HALT : state;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            instr_pc <= '0;
        end else if (redirect || state == FAULT) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= bus.imem_q;
            instr_pc <= pc;
        end else if (state == HALT && bus.instr_ready) begin
            valid <= 1'b0;
        end
    assign bus.imem_addr = pc[AW+1:2];
    assign bus.instr_valid = valid;
    assign bus.instr = instr;
    assign bus.instr_pc = instr_pc;
    assign bus.fault = state == FAULT;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage; define FETCH_HALT_DETECT_EN to cover halt.
module tb_fetch_stage;
    import fetch_pkg::*;
    localparam int N = 64;
    localparam int AW = 6;
    typedef struct packed {
        logic [31:0] instr;
        logic [N-1:0] pc;
    } xact_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] rom [64];
    xact_t q[$];
    logic [N-1:0] next_pc;
    bit stream_end;
    bit m_fault;
    logic [AW-1:0] fault_addr;
    int vectors = 0;
    int miscompares = 0;

    fetch_stage_if #(.N(N), .AW(AW)) bus ();
    fetch_stage #(.N(N), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    assign bus.imem_q = rom[bus.imem_addr];

    function automatic logic [AW-1:0] word_of(logic [N-1:0] a);
        return AW'((a / 4) % 64);
    endfunction

    task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected delivery stream: consecutive words from the last redirect target
    function automatic void topup();
        xact_t x;
        while (!stream_end && q.size() < 8) begin
            x.pc = next_pc;
            x.instr = rom[word_of(next_pc)];
            next_pc += 4;
`ifdef FETCH_HALT_DETECT_EN
            if (x.instr == HALT_WORD) stream_end = 1'b1;
`endif
            q.push_back(x);
        end
    endfunction

    function automatic void restart(logic [N-1:0] a);
        q.delete();
        next_pc = a;
        stream_end = 1'b0;
        topup();
    endfunction

    // The PC sits one word past the presented instruction, or on it during a bubble
    function automatic logic [AW-1:0] exp_addr();
        if (q.size() == 0) return '0;
        return word_of(bus.instr_valid ? q[0].pc + 4 : q[0].pc);
    endfunction

    function automatic bit can_redirect();
`ifdef FETCH_HALT_DETECT_EN
        if (bus.halt) return 1'b1;
        for (int i = 0; i < 2 && i < q.size(); i++)
            if (q[i].instr == HALT_WORD) return 1'b0;
`endif
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (m_fault) begin
                chk("fault_flag", bus.fault, 1);
                chk("fault_valid", bus.instr_valid, 0);
                chk("fault_pc_frozen", bus.imem_addr, fault_addr);
            end else begin
                chk("fault_clear", bus.fault, 0);
`ifndef FETCH_HALT_DETECT_EN
                chk("halt_tied", bus.halt, 0);
`endif
                if (!bus.halt && q.size() > 0) chk("imem_addr", bus.imem_addr, exp_addr());
                if (bus.instr_valid) begin
                    if (q.size() == 0) chk("unexpected_valid", bus.instr_valid, 0);
                    else begin
                        chk("instr", bus.instr, q[0].instr);
                        chk("instr_pc", bus.instr_pc, q[0].pc);
                        if (bus.instr_ready) void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(bit r, bit b, logic [N-1:0] t);
        bit live;
        live = b && !m_fault && !bus.halt;
        if (live && t[1:0] != 2'b00) fault_addr = exp_addr();
        bus.instr_ready = r;
        bus.br_taken = b;
        bus.br_target = t;
        @(posedge clk);
        #1;
        bus.br_taken = 1'b0;
        if (live && t[1:0] != 2'b00) begin
            m_fault = 1'b1;
            q.delete();
            stream_end = 1'b1;
        end else if (live) restart(t);
        else topup();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.br_taken = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        chk("rst_imem_addr", bus.imem_addr, 0);
        chk("rst_halt", bus.halt, 0);
        chk("rst_fault", bus.fault, 0);
        q.delete();
        m_fault = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        restart('0);
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_target = '0;
        m_fault = 1'b0;
        stream_end = 1'b1;
        for (int i = 0; i < 64; i++) rom[i] = 32'h8b000000 + 32'(i) * 32'h00010203;
        rom[0] = 32'hf8000001;
        rom[1] = 32'hf8008002;
        rom[2] = 32'hf8000203;
        rom[16] = 32'hf8048005;
        rom[46] = HALT_WORD;
        @(posedge clk);
        #1;
        do_reset();
        repeat (3) step(1, 0, '0);
        repeat (3) step(0, 0, '0);
        repeat (2) step(1, 0, '0);
        step(1, 1, 64'h40);
        repeat (3) step(1, 0, '0);
        step(0, 1, 64'hfc);
        repeat (4) step(1, 0, '0);
        step(1, 1, 64'h1f0);
        repeat (3) step(1, 0, '0);
        step(1, 1, 64'hffff_ffff_ffff_fff8);
        repeat (4) step(1, 0, '0);
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0 && can_redirect(),
                 N'($urandom_range(0, 1023)) << 2);
`ifdef FETCH_HALT_DETECT_EN
        for (int i = 0; i < 300 && !(bus.halt && q.size() == 0); i++) step(1, 0, '0);
        chk("halt_reached", bus.halt, 1);
        step(1, 1, 64'h40);
        repeat (4) step(1, 0, '0);
        chk("halt_held", bus.halt, 1);
        chk("halt_no_valid", bus.instr_valid, 0);
`endif
        do_reset();
        repeat (5) step(1, 0, '0);
        step(1, 1, 64'h42);
        repeat (4) step($urandom_range(0, 1) != 0, 1, 64'h80);
        chk("fault_out", bus.fault, 1);
        do_reset();
        repeat (4) step(1, 0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
